// File: rtl/sram_model_pkg.sv
// sram_model_pkg: shared types, read-during-write policy codes and byte-merge helper
package sram_model_pkg;
  typedef enum logic {IDLE, CLEAR} state_t;
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;
  function automatic logic [7:0] merge_byte(input logic [7:0] old_b, input logic [7:0] new_b, input logic en);
    return en ? new_b : old_b;
  endfunction
endpackage

// File: rtl/sram_1rw_nr_model_if.sv
// sram_1rw_nr_model_if: request/response bundle for one RW port, NUM_R read ports and status
interface sram_1rw_nr_model_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_R      = 2
);
  logic                          csb0;
  logic                          web0;
  logic [DATA_WIDTH/8-1:0]       wmask0;
  logic [ADDR_WIDTH-1:0]         addr0;
  logic [DATA_WIDTH-1:0]         din0;
  logic [DATA_WIDTH-1:0]         dout0;
  logic                          dvalid0;
  logic [NUM_R-1:0]              csb1;
  logic [NUM_R*ADDR_WIDTH-1:0]   addr1;
  logic [NUM_R*DATA_WIDTH-1:0]   dout1;
  logic [NUM_R-1:0]              dvalid1;
  logic                          busy;
  logic                          collision;
  logic [15:0]                   collision_cnt;
  logic                          addr_err;
  modport master (
    output csb0, web0, wmask0, addr0, din0, csb1, addr1,
    input  dout0, dvalid0, dout1, dvalid1, busy, collision, collision_cnt, addr_err
  );
  modport slave (
    input  csb0, web0, wmask0, addr0, din0, csb1, addr1,
    output dout0, dvalid0, dout1, dvalid1, busy, collision, collision_cnt, addr_err
  );
endinterface

// File: rtl/sram_rd_pipe.sv
// sram_rd_pipe: 1- or 2-cycle read return stage; dout holds between completed reads
module sram_rd_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dvalid
);
  logic                  v_q;
  logic [DATA_WIDTH-1:0] d_q;
  if (READ_LATENCY == 2) begin : g_lat2
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else begin
        v_q <= req;
        if (req) d_q <= din;
      end
  end else begin : g_lat1
    assign v_q = req;
    assign d_q = din;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dout   <= '0;
      dvalid <= 1'b0;
    end else begin
      dvalid <= v_q;
      if (v_q) dout <= d_q;
    end
endmodule

// File: rtl/sram_1rw_nr_model.sv
// sram_1rw_nr_model: 1RW + NUM_R read SRAM with byte mask, post-reset clear and collision monitor
module sram_1rw_nr_model
  import sram_model_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int RAM_DEPTH    = 1 << ADDR_WIDTH,
  parameter int NUM_R        = 2,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0,
  parameter int INIT_ZERO    = 1
) (
  input logic                 clk0,
  input logic                 rst0,
  sram_1rw_nr_model_if.slave  bus
);
  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH = (ADDR_WIDTH + 1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(RAM_DEPTH - 1);
  state_t                  state, state_nx;
  logic [ADDR_WIDTH-1:0]   clr_addr, clr_nx;
  logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];
  logic                    act, ok0, wr, rd0;
  logic [DATA_WIDTH-1:0]   old0, new0;
  logic [NUM_R-1:0]        ok1, rd1, coll, dv1;
  logic [DATA_WIDTH-1:0]   rdata1 [NUM_R];
  logic [DATA_WIDTH-1:0]   q1 [NUM_R];
  always_ff @(posedge clk0 or posedge rst0)
    if (rst0) begin
      state    <= (INIT_ZERO != 0) ? CLEAR : IDLE;
      clr_addr <= '0;
    end else begin
      state    <= state_nx;
      clr_addr <= clr_nx;
    end
  always_comb begin
    state_nx = (state == CLEAR && clr_addr == LAST) ? IDLE : state;
    clr_nx   = (state == CLEAR) ? clr_addr + 1'b1 : clr_addr;
  end
  assign bus.busy = (state == CLEAR);
  // Requests are also blocked while reset is held so memory stays untouched by reset.
  assign act  = !bus.busy && !rst0;
  assign ok0  = {1'b0, bus.addr0} < DEPTH;
  assign wr   = act && !bus.csb0 && !bus.web0 && ok0;
  assign rd0  = act && !bus.csb0 && bus.web0;
  assign old0 = ok0 ? mem[bus.addr0] : '0;
  always_comb begin
    new0 = old0;
    for (int b = 0; b < NB; b++)
      new0[b*8 +: 8] = merge_byte(old0[b*8 +: 8], bus.din0[b*8 +: 8], bus.wmask0[b]);
  end
  for (genvar k = 0; k < NUM_R; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] a;
    assign a         = bus.addr1[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign ok1[k]    = {1'b0, a} < DEPTH;
    assign rd1[k]    = act && !bus.csb1[k];
    assign coll[k]   = rd1[k] && wr && (a == bus.addr0);
    assign rdata1[k] = !ok1[k] ? '0 : (coll[k] && RDW_MODE == RDW_NEW) ? new0 : mem[a];
    sram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .READ_LATENCY(READ_LATENCY)) u_pipe (
      .clk(clk0), .rst(rst0), .req(rd1[k]), .din(rdata1[k]), .dout(q1[k]), .dvalid(dv1[k])
    );
    assign bus.dout1[k*DATA_WIDTH +: DATA_WIDTH] = q1[k];
    assign bus.dvalid1[k] = dv1[k];
  end
  sram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .READ_LATENCY(READ_LATENCY)) u_pipe0 (
    .clk(clk0), .rst(rst0), .req(rd0), .din(old0), .dout(bus.dout0), .dvalid(bus.dvalid0)
  );
  always_ff @(posedge clk0)
    if (bus.busy && !rst0) mem[clr_addr] <= '0;
    else if (wr) mem[bus.addr0] <= new0;
  always_ff @(posedge clk0 or posedge rst0)
    if (rst0) begin
      bus.collision     <= 1'b0;
      bus.collision_cnt <= '0;
      bus.addr_err      <= 1'b0;
    end else begin
      if (|coll) begin
        bus.collision <= 1'b1;
        if (bus.collision_cnt != 16'hFFFF) bus.collision_cnt <= bus.collision_cnt + 16'd1;
      end
      if (act && ((!bus.csb0 && !ok0) || |(~bus.csb1 & ~ok1))) bus.addr_err <= 1'b1;
    end
endmodule

// File: doc/sram_1rw_nr_model.md
Name: sram_1rw_nr_model

Overview:
- Parametrised successor of the single-RW/single-R SRAM behavioural model.
- One RW port (port 0) plus NUM_R read-only ports, all on one clock.
- Adds byte write mask, configurable read latency, and a defined read-during-write policy.
- Adds a post-reset memory-clear sequencer and collision/error monitoring. Synthesizable; the memory array is inferred.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, address width.
- RAM_DEPTH, 1<<ADDR_WIDTH, number of words; may be less than 2^ADDR_WIDTH.
- NUM_R, 2, number of read-only ports (1..4).
- READ_LATENCY, 1, request-to-dout latency in cycles (1 or 2).
- RDW_MODE, 0, same-address write/read collision policy: 0 = old data, 1 = new data.
- INIT_ZERO, 1, 1 = clear the array after reset.

Ports:
- clk0  in  1  sole clock; all state updates on posedge.
- rst0  in  1  asynchronous, active-high reset.
- csb0  in  1  port 0 chip select, active low.
- web0  in  1  port 0 write enable, active low.
- wmask0  in  DATA_WIDTH/8  byte write enables for port 0.
- addr0  in  ADDR_WIDTH  port 0 address.
- din0  in  DATA_WIDTH  port 0 write data.
- dout0  out  DATA_WIDTH  port 0 read data.
- dvalid0  out  1  dout0 updated this cycle.
- csb1  in  NUM_R  per-read-port chip select, active low.
- addr1  in  NUM_R*ADDR_WIDTH  read addresses; port k uses slice [k*ADDR_WIDTH +: ADDR_WIDTH].
- dout1  out  NUM_R*DATA_WIDTH  read data, sliced per port.
- dvalid1  out  NUM_R  per-port valid.
- busy  out  1  clear sequence in progress; all requests ignored.
- collision  out  1  sticky; a port 0 write and a port-1 read hit the same address in the same cycle.
- collision_cnt  out  16  collision event count; saturates at 0xFFFF.
- addr_err  out  1  sticky; an enabled access had address >= RAM_DEPTH.

Behaviour:
- Reset values, as rst0 asserts: dout0/dout1 = 0, dvalid* = 0, collision = 0, collision_cnt = 0, addr_err = 0, pipeline registers = 0.
- Reset does not alter memory contents.
- busy = 1 if INIT_ZERO = 1, else 0.
- FSM states: IDLE, CLEAR (only reachable when INIT_ZERO = 1).
  - rst0 -> CLEAR with clr_addr = 0.
  - CLEAR writes 0 to mem[clr_addr] and increments clr_addr each cycle.
  - Leaves CLEAR after writing RAM_DEPTH-1, so busy is high for exactly RAM_DEPTH cycles after reset release.
  - rst0 during CLEAR restarts the sweep from 0.
- While busy: csb*/web0 are ignored, dvalid* = 0, no counters change.
- Write (IDLE, csb0 = 0, web0 = 0, addr0 < RAM_DEPTH): at the posedge, byte b of mem[addr0] takes din0 byte b where wmask0[b] = 1; other bytes are unchanged. wmask0 = 0 is a legal no-op write.
- Read (csb = 0, plus web0 = 1 for port 0):
  - Address sampled at posedge N.
  - Data and dvalid appear after posedge N+READ_LATENCY-1, i.e. visible during cycle N+READ_LATENCY.
  - dvalid is a 1-cycle pulse per read.
  - dout holds its last value when no read completes; it never goes X.
- Collision (port 0 writes A while read port k reads A in the same cycle):
  - RDW_MODE 0: port k returns the pre-write word.
  - RDW_MODE 1: port k returns the merged post-write word.
  - collision set; collision_cnt += 1 per cycle with at least one colliding read port (not per port).
- Multiple read ports on the same address in the same cycle: independent and legal; not a collision.
- Out-of-range address:
  - Write is dropped.
  - Read returns 0 with dvalid = 1.
  - addr_err set.
- Sticky flags and counter clear only on rst0.

Decomposition:
- Package sram_model_pkg holds:
  - state typedef {IDLE, CLEAR};
  - RDW_OLD = 0, RDW_NEW = 1;
  - a function merging a word with wmask bytes.
- Sub-module sram_rd_pipe: one per read channel (NUM_R+1 instances).
  - Parameterised by DATA_WIDTH and READ_LATENCY.
  - Registers data and valid, and holds dout when idle.

Test Plan:
All cases use DATA_WIDTH=32, ADDR_WIDTH=6, RAM_DEPTH=48, NUM_R=2.
1. Reset and clear: release rst0 -> busy high for exactly 48 cycles. Then reading addr 47 on port 1[0] -> dout = 0x00000000, dvalid pulse at latency 1, and again at latency 2 with READ_LATENCY=2.
2. Byte mask: write 0xAABBCCDD with wmask 0xF to addr 5, then 0x11223344 with wmask 0b0101 -> read = 0xAA22CC44.
3. Collision: same cycle, port 0 writes 0x12345678 to addr 9 (old value 0xDEADBEEF) while both read ports read addr 9.
   - RDW_MODE 0: both reads return 0xDEADBEEF.
   - RDW_MODE 1: both reads return 0x12345678.
   - collision = 1, collision_cnt = 1.
4. Range: write to addr 50 -> no memory change and addr_err = 1; read addr 60 -> dout = 0 with dvalid = 1.
5. Reset mid-clear: assert rst0 at clear cycle 20 -> all outputs return to reset values at once; after release, busy lasts a full 48 cycles; a request issued during busy produces no dvalid.
6. Counter: 70000 consecutive colliding cycles -> collision_cnt saturates at 0xFFFF.
